// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
//   int_state_t : controller FSM states
//   CAUSE_*     : encodings reported on the cause output
package int_pkg;

    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } int_state_t;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_KEY  = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_ETH  = 2'b10;

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle of peripheral requests, fetch/execute controls and interrupt outputs.
//   slave  : the controller (takes requests/controls, drives pulses, acks, cause, busy)
//   master : the environment around it
interface int_ctrl_if;
    import int_pkg::*;

    logic               key_req;
    logic               eth_req;
    logic               int_en;
    logic               branch;
    logic               rti;
    logic               rsi;
    logic               interrupt_key;
    logic               interrupt_eth;
    logic               key_ack;
    logic               eth_ack;
    logic [CAUSE_W-1:0] cause;
    logic               busy;

    modport slave (
        input  key_req, eth_req, int_en, branch, rti, rsi,
        output interrupt_key, interrupt_eth, key_ack, eth_ack, cause, busy
    );

    modport master (
        output key_req, eth_req, int_en, branch, rti, rsi,
        input  interrupt_key, interrupt_eth, key_ack, eth_ack, cause, busy
    );

endinterface

// File: rtl/int_edge_latch.sv
// Rising-edge detector with a sticky pending bit for one interrupt source.
//   clk, rst_n : clock, synchronous active-low reset
//   i_req      : request level from the peripheral
//   i_clr      : clears the pending bit (source chosen for issue)
//   o_pending  : request seen and not yet issued
module int_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_clr,
    output logic o_pending
);

    logic r_req_d;
    logic r_pending;
    logic w_edge;

    assign w_edge    = i_req & ~r_req_d;
    assign o_pending = r_pending;

    // A new edge beats a same-cycle clear so that request is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_req_d <= i_req;
            if (w_edge) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches key/eth request edges, issues one pulse at a
// time (eth first), then blocks until RTI/RSI plus a restore gap.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requests, int_en, branch, rti/rsi in; pulses, acks, cause, busy out
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    int_ctrl_if.slave  bus
);

    int_state_t           r_state;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic                 r_int_key;
    logic                 r_int_eth;
    logic [CAUSE_W-1:0]   r_cause;
    logic                 r_busy;

    logic w_key_pend;
    logic w_eth_pend;
    logic w_go;
    logic w_clr_key;
    logic w_clr_eth;
    logic w_ret;

    // Issue decision; eth has priority over key.
    assign w_go      = (r_state == IDLE) & bus.int_en & ~bus.branch & (w_key_pend | w_eth_pend);
    assign w_clr_eth = w_go & w_eth_pend;
    assign w_clr_key = w_go & ~w_eth_pend & w_key_pend;
    assign w_ret     = bus.rti | bus.rsi;

    int_edge_latch u_key_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.key_req),
        .i_clr     (w_clr_key),
        .o_pending (w_key_pend)
    );

    int_edge_latch u_eth_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.eth_req),
        .i_clr     (w_clr_eth),
        .o_pending (w_eth_pend)
    );

    // Controller FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_int_key <= 1'b0;
            r_int_eth <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_busy    <= 1'b0;
        end else begin
            r_int_key <= 1'b0;
            r_int_eth <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        if (w_eth_pend) begin
                            r_int_eth <= 1'b1;
                            r_cause   <= CAUSE_ETH;
                        end else begin
                            r_int_key <= 1'b1;
                            r_cause   <= CAUSE_KEY;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= SERVICE;
                end
                SERVICE: begin
                    if (w_ret) begin
                        r_cause <= CAUSE_NONE;
                        if (GAP_CYCLES == 0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Counter counts the remaining GAP cycles after this one.
                            r_state   <= GAP;
                            r_gap_cnt <= GAP_CNT_W'(GAP_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cause <= CAUSE_NONE;
                end
            endcase
        end
    end

    assign bus.interrupt_key = r_int_key;
    assign bus.interrupt_eth = r_int_eth;
    assign bus.key_ack       = r_int_key;
    assign bus.eth_ack       = r_int_eth;
    assign bus.cause         = r_cause;
    assign bus.busy          = r_busy;

endmodule
